rr_mux_reg: RTL and testbench

RR_MUX_REG -- requirements
Module: rr_mux_reg

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/rr_mux_reg.sv | 101 ++++++++++
 tb/tb_rr_mux_reg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings, channel-count limits and index helper
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 32;

    // Channel index that follows idx, wrapping from n-1 back to 0.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority search starting at a rotating pointer
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_CH    = 16,
    localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [SEL_WIDTH-1:0] ptr_i,
    output logic [SEL_WIDTH-1:0] grant_o,
    output logic                 grant_valid_o
);

    // Walk every channel once, beginning at ptr_i, and take the first requester.
    always_comb begin
        int idx;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = int'(ptr_i);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_valid_o && req_i[idx]) begin
                grant_o       = SEL_WIDTH'(idx);
                grant_valid_o = 1'b1;
            end
            idx = next_index(idx, NUM_CH);
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - fixed/round-robin channel mux into a single registered output stage
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter  int BUS_WIDTH = 32,
    parameter  int NUM_CH    = 16,
    localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                        clk_in,
    input  logic                        nreset_in,
    input  logic [NUM_CH*BUS_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]           valid_in,
    output logic [NUM_CH-1:0]           ready_out,
    input  logic                        mode_in,
    input  logic [SEL_WIDTH-1:0]        sel_in,
    output logic [BUS_WIDTH-1:0]        y_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [SEL_WIDTH-1:0]        grant_out
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_num_ch_check
        $error("rr_mux_reg: NUM_CH outside legal range");
    end

    logic [BUS_WIDTH-1:0] y_q, y_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_WIDTH-1:0] rr_grant;
    logic                 rr_grant_valid;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 grant_vld;
    logic                 open;
    logic                 load;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req_i         (valid_in),
        .ptr_i         (rr_ptr_q),
        .grant_o       (rr_grant),
        .grant_valid_o (rr_grant_valid)
    );

    // Pick the granted channel for this cycle; an out-of-range fixed select grants nobody.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        if (mode_in == MODE_RR) begin
            grant_idx = rr_grant;
            grant_vld = rr_grant_valid;
        end else begin
            grant_idx = sel_in;
            grant_vld = (int'(sel_in) < NUM_CH) && valid_in[sel_in];
        end
    end

    assign open      = !valid_q || ready_in;
    assign load      = nreset_in && open && grant_vld;
    assign ready_out = load ? (NUM_CH'(1) << grant_idx) : '0;

    // Next-state: load the granted word when open, drop valid when open with nothing granted.
    always_comb begin
        y_d      = y_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (open) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                y_d     = data_in[int'(grant_idx)*BUS_WIDTH +: BUS_WIDTH];
                grant_d = grant_idx;
                if (mode_in == MODE_RR) begin
                    rr_ptr_d = SEL_WIDTH'(next_index(int'(grant_idx), NUM_CH));
                end
            end
        end
    end

    // Output register and rotating pointer; reset discards any held word at once.
    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            y_q      <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            y_q      <= y_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign y_out     = y_q;
    assign valid_out = valid_q;
    assign grant_out = grant_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - self-checking bench for rr_mux_reg
module tb_rr_mux_reg;

    localparam int NCH   = 16;
    localparam int NCH12 = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*32-1:0] data;
    logic [NCH-1:0]    vin;
    logic [NCH-1:0]    rout;
    logic              mode;
    logic [3:0]        sel;
    logic [31:0]       y;
    logic              vout;
    logic              rdy;
    logic [3:0]        gnt;

    logic [NCH12*32-1:0] data12;
    logic [NCH12-1:0]    vin12;
    logic [NCH12-1:0]    rout12;
    logic                mode12;
    logic [3:0]          sel12;
    logic [31:0]         y12;
    logic                vout12;
    logic                rdy12;
    logic [3:0]          gnt12;

    int vectors     = 0;
    int miscompares = 0;

    logic        exp_valid;
    logic [31:0] exp_y;
    int          exp_grant;
    int          exp_ptr;

    always #5 clk = ~clk;

    rr_mux_reg #(.BUS_WIDTH(32), .NUM_CH(NCH)) u_dut (
        .clk_in    (clk),
        .nreset_in (rst_n),
        .data_in   (data),
        .valid_in  (vin),
        .ready_out (rout),
        .mode_in   (mode),
        .sel_in    (sel),
        .y_out     (y),
        .valid_out (vout),
        .ready_in  (rdy),
        .grant_out (gnt)
    );

    rr_mux_reg #(.BUS_WIDTH(32), .NUM_CH(NCH12)) u_dut12 (
        .clk_in    (clk),
        .nreset_in (rst_n),
        .data_in   (data12),
        .valid_in  (vin12),
        .ready_out (rout12),
        .mode_in   (mode12),
        .sel_in    (sel12),
        .y_out     (y12),
        .valid_out (vout12),
        .ready_in  (rdy12),
        .grant_out (gnt12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: who gets the grant, from the selection rules alone (-1 = nobody).
    function automatic int model_grant(input logic m, input logic [3:0] s,
                                       input logic [NCH-1:0] v, input int p);
        if (m == 1'b0) begin
            return v[s] ? int'(s) : -1;
        end
        for (int k = 0; k < NCH; k++) begin
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_y     = '0;
        exp_grant = 0;
        exp_ptr   = 0;
    endtask

    // One clock: check ready_out before the edge, advance the model, check outputs after.
    task automatic step(input string tag);
        int          g;
        logic        op;
        logic [31:0] er;
        #1;
        g  = model_grant(mode, sel, vin, exp_ptr);
        op = !exp_valid || rdy;
        er = (rst_n && op && g >= 0) ? (32'd1 << g) : 32'd0;
        check({tag, "_ready"}, 32'(rout), er);
        if (rst_n && op) begin
            if (g >= 0) begin
                exp_y     = data[g*32 +: 32];
                exp_grant = g;
                exp_valid = 1'b1;
                if (mode) exp_ptr = (g + 1) % NCH;
            end else begin
                exp_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(vout), 32'(exp_valid));
        check({tag, "_y"}, y, exp_y);
        check({tag, "_grant"}, 32'(gnt), 32'(exp_grant));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        data   = '0;
        vin    = '1;
        mode   = 1'b0;
        sel    = 4'd0;
        rdy    = 1'b1;
        data12 = '0;
        for (int k = 0; k < NCH12; k++) data12[k*32 +: 32] = 32'h1200 + k;
        vin12  = '1;
        mode12 = 1'b0;
        sel12  = 4'd13;
        rdy12  = 1'b1;
        model_reset();

        // Reset state with every channel requesting
        #12;
        check("rst_valid", 32'(vout), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_grant", 32'(gnt), 32'd0);
        check("rst_ready", 32'(rout), 32'd0);
        check("rst_ready12", 32'(rout12), 32'd0);

        // First load lands on the first edge after release
        vin = 16'h0001;
        data[0 +: 32] = 32'hCAFE0000;
        @(negedge clk);
        rst_n = 1'b1;
        step("first");
        check("first_y_const", y, 32'hCAFE0000);

        // Fixed select of channel 5
        sel = 4'd5;
        vin = 16'h0020;
        data[5*32 +: 32] = 32'hA5A5A5A5;
        step("fix5");
        check("fix5_y_const", y, 32'hA5A5A5A5);
        check("fix5_grant_const", 32'(gnt), 32'd5);
        check("fix5_valid_const", 32'(vout), 32'd1);

        // Backpressure: held word stays put for three cycles
        sel = 4'd7;
        vin = 16'h00A0;
        data[7*32 +: 32] = 32'h77777777;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            check("bp_y_hold", y, 32'hA5A5A5A5);
            check("bp_grant_hold", 32'(gnt), 32'd5);
            check("bp_ready_zero", 32'(rout), 32'd0);
        end
        rdy = 1'b1;
        #1;
        check("bp_ready_return", 32'(rout), 32'h0080);
        step("bp_resume");
        check("bp_resume_y", y, 32'h77777777);
        check("bp_resume_grant", 32'(gnt), 32'd7);

        // Round-robin with all channels requesting: 0..15,0 back to back
        for (int k = 0; k < NCH; k++) data[k*32 +: 32] = 32'h1000 + k;
        mode = 1'b1;
        vin  = '1;
        for (int i = 0; i < 17; i++) begin
            step("rr_all");
            check("rr_all_grant_seq", 32'(gnt), 32'(i % NCH));
            check("rr_all_no_bubble", 32'(vout), 32'd1);
            check("oor12_ready", 32'(rout12), 32'd0);
            check("oor12_valid", 32'(vout12), 32'd0);
        end

        // Wrap-around from pointer 14 with requests on 2 and 15
        vin = 16'h2000;
        step("wrap_setup");
        check("wrap_setup_grant", 32'(gnt), 32'd13);
        vin = 16'h8004;
        step("wrap_a");
        check("wrap_a_grant", 32'(gnt), 32'd15);
        step("wrap_b");
        check("wrap_b_grant", 32'(gnt), 32'd2);
        vin = 16'h000C;
        step("wrap_ptr3");
        check("wrap_ptr3_grant", 32'(gnt), 32'd3);

        // Asynchronous reset mid-cycle while a word is held
        rdy = 1'b0;
        vin = '1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(vout), 32'd0);
        check("arst_y", y, 32'd0);
        check("arst_grant", 32'(gnt), 32'd0);
        check("arst_ready", 32'(rout), 32'd0);
        #3;
        check("arst_ready_low", 32'(rout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy   = 1'b1;
        step("post_rst");
        check("post_rst_grant", 32'(gnt), 32'd0);

        // Fixed mode on the 12-channel instance: in-range top channel, then out of range
        sel12 = 4'd11;
        #1;
        check("in12_ready", 32'(rout12), 32'h0800);
        step("in12");
        check("in12_y", y12, 32'h120B);
        check("in12_grant", 32'(gnt12), 32'd11);
        check("in12_valid", 32'(vout12), 32'd1);
        sel12 = 4'd13;
        step("oor12");
        check("oor12_drop_valid", 32'(vout12), 32'd0);
        check("oor12_y_hold", y12, 32'h120B);
        check("oor12_grant_hold", 32'(gnt12), 32'd11);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NCH; k++) data[k*32 +: 32] = $urandom;
            vin  = (i % 3 == 0) ? NCH'($urandom & $urandom & $urandom) : NCH'($urandom);
            mode = 1'($urandom % 2);
            sel  = 4'($urandom);
            rdy  = ($urandom % 4) != 0;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
